// File: rtl/filt_csr_if.sv
// Register bus between a CSR master and the filter control/status block.
// A master holds req with stable wr_en/addr/wr_data until the one-cycle ack.
interface filt_csr_if #(
    parameter int DW = 8
);
    logic          req;
    logic          wr_en;
    logic [7:0]    addr;
    logic [DW-1:0] wr_data;
    logic          ack;
    logic [DW-1:0] rd_data;
    logic          err;

    modport master (output req, wr_en, addr, wr_data, input ack, rd_data, err);
    modport slave  (input req, wr_en, addr, wr_data, output ack, rd_data, err);
endinterface

// File: rtl/filt_csr.sv
// Filter control/status registers: shadow/active coefficient, divider and ratio
// settings committed on a sample boundary, ADC snapshot and saturation status.
module filt_csr #(
    parameter int         DW       = 8,
    parameter int         NUM_COEF = 3,
    parameter int         RW       = 2,
    parameter logic [7:0] CHIP_ID  = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    filt_csr_if.slave              bus,
    input  logic signed [DW-1:0]   I_adc_data,
    input  logic                   I_adc_valid,
    input  logic                   I_sample_tick,
    input  logic                   I_sat_evt,
    output logic [NUM_COEF*DW-1:0] O_coef,
    output logic [DW-1:0]          O_coef_div,
    output logic [RW-1:0]          O_decimation_ratio,
    output logic                   O_conv_en,
    output logic                   O_commit_pending
);
    typedef logic signed [DW-1:0] word_t;
    localparam logic [DW-1:0] ID_EXT = DW'(CHIP_ID);

    word_t          coef_sh_q  [NUM_COEF];
    word_t          coef_sh_d  [NUM_COEF];
    word_t          coef_act_q [NUM_COEF];
    word_t          coef_act_d [NUM_COEF];
    word_t          div_sh_q, div_sh_d, div_act_q, div_act_d;
    logic [RW-1:0]  ratio_sh_q, ratio_sh_d, ratio_act_q, ratio_act_d;
    logic           conv_en_q, conv_en_d, pending_q, pending_d;
    logic           sat_sticky_q, sat_sticky_d;
    logic [DW-1:0]  sat_cnt_q, sat_cnt_d;
    word_t          adc_snap_q, adc_snap_d;
    logic           ack_q, ack_d, err_q, err_d;
    logic [DW-1:0]  rd_q, rd_d;

    logic          accept, hit, ro, err_v, wr_ok, commit_req, w1c, cnt_clr, do_commit;
    logic [DW-1:0] rd_v;

    always_comb begin
        coef_sh_d    = coef_sh_q;
        coef_act_d   = coef_act_q;
        div_sh_d     = div_sh_q;
        div_act_d    = div_act_q;
        ratio_sh_d   = ratio_sh_q;
        ratio_act_d  = ratio_act_q;
        conv_en_d    = conv_en_q;
        pending_d    = pending_q;
        rd_d         = rd_q;
        err_d        = err_q;
        adc_snap_d   = I_adc_valid ? I_adc_data : adc_snap_q;
        commit_req   = 1'b0;
        w1c          = 1'b0;
        cnt_clr      = 1'b0;
        hit          = 1'b0;
        ro           = 1'b0;
        rd_v         = '0;

        // Accept only while no ack is outstanding, giving two cycles per transaction.
        accept = bus.req & ~ack_q;
        ack_d  = accept;

        for (int k = 0; k < NUM_COEF; k++) begin
            if (bus.addr == 8'(k)) begin
                hit  = 1'b1;
                rd_v = coef_sh_q[k];
            end
        end
        case (bus.addr)
            8'h10: begin hit = 1'b1; rd_v = div_sh_q; end
            8'h11: begin hit = 1'b1; rd_v = DW'(ratio_sh_q); end
            8'h12: begin hit = 1'b1; ro = 1'b1; rd_v = ID_EXT; end
            8'h13: begin hit = 1'b1; rd_v = DW'(conv_en_q); end
            8'h14: begin hit = 1'b1; rd_v = DW'({sat_sticky_q, pending_q}); end
            8'h15: begin hit = 1'b1; ro = 1'b1; rd_v = adc_snap_q; end
            8'h16: begin hit = 1'b1; rd_v = sat_cnt_q; end
            default: ;
        endcase

        err_v = ~hit | (bus.wr_en & ro);
        wr_ok = accept & bus.wr_en & ~err_v;
        if (accept) begin
            rd_d  = err_v ? '0 : rd_v;
            err_d = err_v;
        end

        if (wr_ok) begin
            for (int k = 0; k < NUM_COEF; k++) begin
                if (bus.addr == 8'(k)) coef_sh_d[k] = bus.wr_data;
            end
            case (bus.addr)
                8'h10: div_sh_d = bus.wr_data;
                8'h11: ratio_sh_d = bus.wr_data[RW-1:0];
                8'h13: begin conv_en_d = bus.wr_data[0]; commit_req = bus.wr_data[1]; end
                8'h14: w1c = bus.wr_data[1];
                8'h16: cnt_clr = 1'b1;
                default: ;
            endcase
        end

        // Pending is only set at the write edge, so a tick in that same cycle never commits.
        do_commit = pending_q & (I_sample_tick | ~conv_en_q);
        if (do_commit) begin
            coef_act_d  = coef_sh_q;
            div_act_d   = div_sh_q;
            ratio_act_d = ratio_sh_q;
            pending_d   = 1'b0;
        end else if (commit_req) begin
            pending_d = 1'b1;
        end

        sat_sticky_d = I_sat_evt | (sat_sticky_q & ~w1c);
        sat_cnt_d    = sat_cnt_q;
        if (cnt_clr)                          sat_cnt_d = DW'(I_sat_evt);
        else if (I_sat_evt && sat_cnt_q != '1) sat_cnt_d = sat_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_COEF; k++) begin
                coef_sh_q[k]  <= (k == 0) ? word_t'(1) : '0;
                coef_act_q[k] <= (k == 0) ? word_t'(1) : '0;
            end
            div_sh_q     <= '0;
            div_act_q    <= '0;
            ratio_sh_q   <= RW'(1);
            ratio_act_q  <= RW'(1);
            conv_en_q    <= 1'b0;
            pending_q    <= 1'b0;
            sat_sticky_q <= 1'b0;
            sat_cnt_q    <= '0;
            adc_snap_q   <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            rd_q         <= '0;
        end else begin
            coef_sh_q    <= coef_sh_d;
            coef_act_q   <= coef_act_d;
            div_sh_q     <= div_sh_d;
            div_act_q    <= div_act_d;
            ratio_sh_q   <= ratio_sh_d;
            ratio_act_q  <= ratio_act_d;
            conv_en_q    <= conv_en_d;
            pending_q    <= pending_d;
            sat_sticky_q <= sat_sticky_d;
            sat_cnt_q    <= sat_cnt_d;
            adc_snap_q   <= adc_snap_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rd_q         <= rd_d;
        end
    end

    always_comb begin
        O_coef = '0;
        for (int k = 0; k < NUM_COEF; k++) O_coef[k*DW +: DW] = coef_act_q[k];
    end

    assign O_coef_div         = div_act_q;
    assign O_decimation_ratio = ratio_act_q;
    assign O_conv_en          = conv_en_q;
    assign O_commit_pending   = pending_q;
    assign bus.ack            = ack_q;
    assign bus.rd_data        = rd_q;
    assign bus.err            = err_q;
endmodule

// File: tb/tb_filt_csr.sv
// Directed bench for filt_csr: a vector table for bus decode plus hand-written
// sequences for commit timing, saturation status, ADC capture and reset abort.
module tb_filt_csr;
    logic              clk;
    logic              rst_n;
    logic signed [7:0] I_adc_data;
    logic              I_adc_valid, I_sample_tick, I_sat_evt;
    logic [23:0]       O_coef;
    logic [7:0]        O_coef_div;
    logic [1:0]        O_decimation_ratio;
    logic              O_conv_en, O_commit_pending;

    int n_vec  = 0;
    int n_miss = 0;

    filt_csr_if #(.DW(8)) csr ();

    filt_csr #(.DW(8), .NUM_COEF(3), .RW(2), .CHIP_ID(8'hA5)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bus                (csr),
        .I_adc_data         (I_adc_data),
        .I_adc_valid        (I_adc_valid),
        .I_sample_tick      (I_sample_tick),
        .I_sat_evt          (I_sat_evt),
        .O_coef             (O_coef),
        .O_coef_div         (O_coef_div),
        .O_decimation_ratio (O_decimation_ratio),
        .O_conv_en          (O_conv_en),
        .O_commit_pending   (O_commit_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit         wr;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        bit         e;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Starts at posedge+1, returns just after the accept edge with req dropped.
    task automatic xfer(input bit w, input logic [7:0] a, input logic [7:0] d,
                        input bit tick, input bit sat,
                        output logic [7:0] rd, output logic e);
        csr.req = 1'b1; csr.wr_en = w; csr.addr = a; csr.wr_data = d;
        I_sample_tick = tick; I_sat_evt = sat;
        @(posedge clk); #1;
        chk($sformatf("ack_rise a=%0h", a), csr.ack, 1);
        rd = csr.rd_data;
        e  = csr.err;
        csr.req = 1'b0; csr.wr_en = 1'b0;
        I_sample_tick = 1'b0; I_sat_evt = 1'b0;
    endtask

    task automatic gap();
        @(posedge clk); #1;
        chk("ack_drop", csr.ack, 0);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] rd;
        logic       e;
        xfer(1'b0, a, 8'h00, 1'b0, 1'b0, rd, e);
        chk({nm, "_err"}, e, 0);
        chk(nm, rd, exp);
        gap();
    endtask

    task automatic wr_do(input logic [7:0] a, input logic [7:0] d, input bit tick, input bit sat);
        logic [7:0] rd;
        logic       e;
        xfer(1'b1, a, d, tick, sat, rd, e);
        chk($sformatf("wr_err a=%0h", a), e, 0);
    endtask

    initial begin
        logic [7:0] rd;
        logic       e;

        tbl[0]  = '{0, 8'h00, 8'h00, 8'h01, 0};
        tbl[1]  = '{0, 8'h10, 8'h00, 8'h00, 0};
        tbl[2]  = '{0, 8'h11, 8'h00, 8'h01, 0};
        tbl[3]  = '{0, 8'h12, 8'h00, 8'hA5, 0};
        tbl[4]  = '{0, 8'h13, 8'h00, 8'h00, 0};
        tbl[5]  = '{0, 8'h14, 8'h00, 8'h00, 0};
        tbl[6]  = '{0, 8'h20, 8'h00, 8'h00, 1};
        tbl[7]  = '{1, 8'h12, 8'h00, 8'h00, 1};
        tbl[8]  = '{0, 8'h12, 8'h00, 8'hA5, 0};
        tbl[9]  = '{1, 8'h15, 8'h11, 8'h00, 1};
        tbl[10] = '{1, 8'h01, 8'h55, 8'h00, 0};
        tbl[11] = '{0, 8'h01, 8'h00, 8'h55, 0};
        tbl[12] = '{1, 8'h11, 8'hFF, 8'h00, 0};
        tbl[13] = '{0, 8'h11, 8'h00, 8'h03, 0};
        tbl[14] = '{0, 8'h03, 8'h00, 8'h00, 1};
        tbl[15] = '{1, 8'hFF, 8'h12, 8'h00, 1};

        rst_n = 1'b0;
        csr.req = 1'b0; csr.wr_en = 1'b0; csr.addr = 8'h00; csr.wr_data = 8'h00;
        I_adc_data = '0; I_adc_valid = 1'b0; I_sample_tick = 1'b0; I_sat_evt = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_coef",  O_coef, 24'h000001);
        chk("rst_div",   O_coef_div, 8'h00);
        chk("rst_ratio", O_decimation_ratio, 2'd1);
        chk("rst_conv",  O_conv_en, 0);
        chk("rst_pend",  O_commit_pending, 0);
        chk("rst_ack",   csr.ack, 0);
        chk("rst_rd",    csr.rd_data, 8'h00);
        chk("rst_err",   csr.err, 0);

        for (int i = 0; i < 16; i++) begin
            xfer(tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0, 1'b0, rd, e);
            chk($sformatf("vec%0d_err", i), e, tbl[i].e);
            if (!tbl[i].wr || tbl[i].e) chk($sformatf("vec%0d_rd", i), rd, tbl[i].rd);
            gap();
        end
        chk("no_commit_yet", O_coef, 24'h000001);

        // Commit with conv_en=1 waits for a tick strictly after the commit write.
        wr_do(8'h13, 8'h01, 1'b0, 1'b0); gap();
        wr_do(8'h02, 8'h7F, 1'b0, 1'b0); gap();
        chk("shadow_only", O_coef, 24'h000001);
        wr_do(8'h13, 8'h03, 1'b1, 1'b0);
        chk("pend_set", O_commit_pending, 1);
        chk("same_tick_ign", O_coef, 24'h000001);
        gap(); gap();
        chk("wait_tick_coef", O_coef, 24'h000001);
        chk("wait_tick_pend", O_commit_pending, 1);
        rd_chk("status_pend", 8'h14, 8'h01);
        I_sample_tick = 1'b1;
        @(posedge clk); #1;
        I_sample_tick = 1'b0;
        chk("tick_coef",  O_coef, 24'h7F5501);
        chk("tick_ratio", O_decimation_ratio, 2'd3);
        chk("tick_pend",  O_commit_pending, 0);
        chk("tick_conv",  O_conv_en, 1);

        // conv_en=0 commits one edge after the write, no tick needed.
        wr_do(8'h10, 8'h04, 1'b0, 1'b0); gap();
        wr_do(8'h13, 8'h02, 1'b0, 1'b0);
        chk("direct_pend", O_commit_pending, 1);
        chk("direct_div0", O_coef_div, 8'h00);
        gap();
        chk("direct_div",  O_coef_div, 8'h04);
        chk("direct_pclr", O_commit_pending, 0);
        chk("direct_conv", O_conv_en, 0);

        // Saturation counter and sticky status.
        I_sat_evt = 1'b1;
        repeat (300) @(posedge clk);
        #1 I_sat_evt = 1'b0;
        rd_chk("satcnt_max", 8'h16, 8'hFF);
        rd_chk("sticky_set", 8'h14, 8'h02);
        wr_do(8'h14, 8'h02, 1'b0, 1'b1); gap();
        rd_chk("w1c_vs_evt", 8'h14, 8'h02);
        rd_chk("satcnt_hold", 8'h16, 8'hFF);
        wr_do(8'h14, 8'h02, 1'b0, 1'b0); gap();
        rd_chk("w1c_clear", 8'h14, 8'h00);
        wr_do(8'h16, 8'h00, 1'b0, 1'b1); gap();
        rd_chk("clr_vs_evt", 8'h16, 8'h01);

        // ADC snapshot holds the last strobed sample.
        I_adc_data = 8'sh80; I_adc_valid = 1'b1;
        @(posedge clk); #1;
        I_adc_data = 8'sh33; I_adc_valid = 1'b0;
        rd_chk("adc_snap", 8'h15, 8'h80);

        // Reset during a write aborts it.
        csr.req = 1'b1; csr.wr_en = 1'b1; csr.addr = 8'h00; csr.wr_data = 8'h22;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_ack",  csr.ack, 0);
        chk("abort_coef", O_coef, 24'h000001);
        chk("abort_div",  O_coef_div, 8'h00);
        csr.req = 1'b0; csr.wr_en = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ack", csr.ack, 0);
        rd_chk("abort_coef0", 8'h00, 8'h01);
        rd_chk("abort_cnt",   8'h16, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
